load_store_unit: RTL
====================

# load_store_unit

Sequencer between the execute stage and `data_memory` of the single-issue RV32I core. Accepts one load/store request at a time and drives the word-only memory port (`mem_read`, `mem_write`, `address`, `write_data`, `read_data`). Implements LB/LH/LW/LBU/LHU and SB/SH/SW: sub-word loads are extracted and extended, and sub-word stores are done as read-modify-write. Signals completion to the pipeline with a one-cycle response pulse.

## Interface
- `RESP_ERR_CODE_W`, 2: width of `resp_err_code`.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: unit can accept a request; high only in IDLE.
- `req_we  in  1`: 1 = store, 0 = load.
- `req_funct3  in  3`: RV32I funct3.
- `req_addr  in  32`: byte address.
- `req_wdata  in  32`: store data, low bytes used for SB/SH.
- `resp_valid  out  1`: one-cycle completion pulse.
- `resp_rdata  out  32`: extended load result; 0 for stores.
- `resp_err  out  1`: request faulted; no memory access was made.
- `resp_err_code  out  2`: 01 = misaligned, 10 = illegal funct3.
- `mem_read  out  1`, `mem_write  out  1`, `mem_address  out  32`, `mem_write_data  out  32`: to `data_memory`.
- `mem_read_data  in  32`: combinational read data from `data_memory`.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready`. On accept, register `we`, `funct3`, `addr`, `wdata`.
- **States:** IDLE, RD, WR, RESP.
  - IDLE → RD: any load, SB, or SH.
  - IDLE → WR: SW.
  - IDLE → RESP: fault.
  - RD → RESP: load.
  - RD → WR: SB/SH.
  - WR → RESP.
  - RESP → IDLE.
- **RD state:**
  - `mem_read=1`, `mem_address = {addr_q[31:2], 2'b00}`.
  - Load: capture the extended result into `resp_rdata`.
  - SB/SH: capture the old word into the merge register.
- **WR state:**
  - `mem_write=1`, same aligned address.
  - `mem_write_data` is `wdata_q` (SW) or the merged word (SB/SH).
- **RESP state:** `resp_valid=1` for exactly one cycle; `resp_err` and `resp_err_code` valid with it.
- **Lanes (little-endian):**
  - Byte lane = `addr[1:0]`; halfword lane = `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - SB replaces one byte with `wdata[7:0]`; SH replaces one halfword with `wdata[15:0]`.
- **Legal funct3:**
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Anything else → err code 10, no access.
- **Misaligned:** halfword with `addr[0]=1`, or word with `addr[1:0]≠0`.
- **Idle outputs:** `mem_*` outputs are 0 outside RD/WR (address and data 0).
- **Ignored requests:** `req_valid` while `req_ready=0` is ignored; the requester holds the request.

## Timing
- Accept at cycle T.
  - Load: RD at T+1, `resp_valid` at T+2.
  - SW: WR at T+1 (memory updated at the T+1 edge), `resp_valid` at T+2.
  - SB/SH: RD at T+1, WR at T+2, `resp_valid` at T+3.
  - Fault: `resp_valid` with `resp_err` at T+1.
- `req_ready` is high again the cycle after RESP. No back-to-back accept in the RESP cycle.
- **Reset values:** IDLE; `req_ready=1` after reset. All other outputs 0: `resp_valid`, `resp_rdata`, `resp_err`, `resp_err_code`, `mem_read`, `mem_write`, `mem_address`, `mem_write_data`.
- **Reset mid-operation:**
  - `mem_write` and `mem_read` are gated by `!rst` in the same cycle, so no write occurs while `rst` is high.
  - The in-flight request is dropped with no response.
- `mem_read_data` is sampled only in RD; it has no combinational path to any output.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned requests fault with code 01.
  - No memory access; response at T+1.
- Not defined:
  - Misalignment is not checked; low address bits below the access size are cleared and the access proceeds normally.
  - `resp_err_code` is never 01. Illegal funct3 still faults with code 10.

## Structure
- Package `lsu_pkg`:
  - funct3 localparams `F3_B=3'b000`, `F3_H=3'b001`, `F3_W=3'b010`, `F3_BU=3'b100`, `F3_HU=3'b101`.
  - State encoding.
  - Err codes `ERR_MISALIGN=2'b01`, `ERR_ILLEGAL=2'b10`.
- Sub-module `lsu_lane_align`: combinational extract/extend for loads and byte/halfword merge for stores. Instanced once. The FSM stays in `load_store_unit`.

## Test plan
- Memory word at 0x100 = 0x00000004; LW 0x100 → `mem_read` at T+1, `resp_rdata=0x00000004` with `resp_valid` at T+2.
- Word at 0x104 = 0x000080FF:
  - LB 0x104 → 0xFFFFFFFF.
  - LBU 0x104 → 0x000000FF.
  - LH 0x104 → 0xFFFF80FF.
  - LHU 0x106 → 0x00000000.
- SB 0x101, `wdata=0x123456AB`, over word 0x00000004 → `mem_read` at T+1, `mem_write` at T+2 with data 0x0000AB04, `resp_valid` at T+3.
- SH 0x102, `wdata=0xBEEF` over 0x00000004 → write 0xBEEF0004. SW 0x108, 0xDEADBEEF → `mem_write` at T+1, `resp_valid` at T+2.
- With `LSU_MISALIGN_TRAP_EN` defined, LW 0x102 → `resp_err=1`, code 01 at T+1, no `mem_read`/`mem_write`. Without the macro → reads word 0x100. Load funct3=011 → code 10 in both builds.
- Assert `rst` in the WR cycle of an SB → `mem_write=0` that cycle, memory unchanged, no `resp_valid`, `req_ready=1` the next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: funct3 codes, error codes and FSM state encoding for the load/store unit
package lsu_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b10;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian sub-word load extract/extend and store byte/halfword merge
module lsu_lane_align import lsu_pkg::*; (
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] m;
  logic [31:0] rep;
  always_comb begin
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    m = funct3[0] ? (lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF) : 32'hFF << {lane, 3'b000};
    rep = funct3[0] ? {2{wdata}} : {4{wdata[7:0]}};
    load_data = funct3 == F3_B  ? {{24{b[7]}}, b} :
                funct3 == F3_BU ? {24'b0, b} :
                funct3 == F3_H  ? {{16{h[15]}}, h} :
                funct3 == F3_HU ? {16'b0, h} : word;
    merged = (word & ~m) | (rep & m);
  end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer over a word-only memory; LSU_MISALIGN_TRAP_EN enables misalignment faults
module load_store_unit import lsu_pkg::*; #(
  parameter int RESP_ERR_CODE_W = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [31:0]                req_addr,
  input  logic [31:0]                req_wdata,
  output logic                       resp_valid,
  output logic [31:0]                resp_rdata,
  output logic                       resp_err,
  output logic [RESP_ERR_CODE_W-1:0] resp_err_code,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [31:0]                mem_address,
  output logic [31:0]                mem_write_data,
  input  logic [31:0]                mem_read_data
);
  state_t state, nxt;
  logic we_q, err_q, accept, legal, fault;
  logic [2:0] f3_q;
  logic [31:0] addr_q, wdata_q, merge_q, rdata_q, eaddr, load_data, merged;
  logic [RESP_ERR_CODE_W-1:0] code_q, code;
`ifdef LSU_MISALIGN_TRAP_EN
  logic mis;
`endif
  always_comb begin
    accept = req_valid && state == IDLE;
    legal = req_funct3 == F3_B || req_funct3 == F3_H || req_funct3 == F3_W ||
            (!req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU));
`ifdef LSU_MISALIGN_TRAP_EN
    mis = (req_funct3[1:0] == 2'b01 && req_addr[0]) || (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
    fault = !legal || mis;
    code = !legal ? RESP_ERR_CODE_W'(ERR_ILLEGAL) : RESP_ERR_CODE_W'(ERR_MISALIGN);
    eaddr = req_addr;
`else
    fault = !legal;
    code = RESP_ERR_CODE_W'(ERR_ILLEGAL);
    eaddr = {req_addr[31:2], req_addr[1] & !req_funct3[1], req_addr[0] & !(req_funct3[1] | req_funct3[0])};
`endif
    nxt = state == IDLE ? (accept ? (fault ? RESP : (req_we && req_funct3 == F3_W) ? WR : RD) : IDLE) :
          state == RD   ? (we_q ? WR : RESP) :
          state == WR   ? RESP : IDLE;
    req_ready = state == IDLE;
    resp_valid = state == RESP;
    mem_read = state == RD && !rst;
    mem_write = state == WR && !rst;
    mem_address = (state == RD || state == WR) ? {addr_q[31:2], 2'b00} : 32'b0;
    mem_write_data = state == WR ? (f3_q == F3_W ? wdata_q : merged) : 32'b0;
    resp_rdata = rdata_q;
    resp_err = err_q;
    resp_err_code = code_q;
  end
  // stores merge against the captured old word, so read data never reaches an output combinationally
  lsu_lane_align u_align (
    .funct3    (f3_q),
    .lane      (addr_q[1:0]),
    .word      (we_q ? merge_q : mem_read_data),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we_q <= 1'b0;
      f3_q <= 3'b0;
      addr_q <= 32'b0;
      wdata_q <= 32'b0;
      merge_q <= 32'b0;
      rdata_q <= 32'b0;
      err_q <= 1'b0;
      code_q <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        we_q <= req_we;
        f3_q <= req_funct3;
        addr_q <= eaddr;
        wdata_q <= req_wdata;
        rdata_q <= 32'b0;
        err_q <= fault;
        code_q <= fault ? code : '0;
      end
      if (state == RD) begin
        if (we_q) merge_q <= mem_read_data;
        else rdata_q <= load_data;
      end
    end
  end
endmodule
